// File: rtl/mod47_pkg.sv
// ----------------------------------------------------------------------------
// mod47_pkg
// Shared constants and types for the mod-47 residue accumulator slice.
//   MODULUS  : modulus; every residue lies in 0..MODULUS-1
//   RES_W    : residue / chunk width in bits
//   CHUNKS   : maximum beats per operand frame (ceil(400/6))
//   CNT_W    : beat counter width
//   residue_t: one residue value
//   count_t  : beat counter value
//   state_t  : accumulator FSM states {ACC, DONE}
// ----------------------------------------------------------------------------
package mod47_pkg;

   localparam int unsigned MODULUS = 47;
   localparam int unsigned RES_W   = 6;
   localparam int unsigned CHUNKS  = 67;
   localparam int unsigned CNT_W   = 7;

   typedef logic [RES_W-1:0] residue_t;
   typedef logic [CNT_W-1:0] count_t;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   // Counter value held while the final permitted beat of a frame is offered
   localparam count_t CNT_LAST = count_t'(CHUNKS - 1);
   localparam count_t CNT_ONE  = count_t'(1);

   // Modulus widened to the carry-inclusive sum width of the adder
   localparam logic [RES_W:0] MOD_WIDE = (RES_W + 1)'(MODULUS);

endpackage

// File: rtl/mod47_add.sv
// ----------------------------------------------------------------------------
// mod47_add
// Combinational (a + b) mod MODULUS for operands already below MODULUS.
// A single conditional subtract is enough because the sum is below 2*MODULUS.
// The same block also folds a raw 6-bit value into range when b_i is zero.
//   a_i   in  RES_W  first operand
//   b_i   in  RES_W  second operand
//   sum_o out RES_W  (a_i + b_i) reduced by at most one MODULUS
// ----------------------------------------------------------------------------
module mod47_add
   import mod47_pkg::*;
(
   input  logic [RES_W-1:0] a_i,
   input  logic [RES_W-1:0] b_i,
   output logic [RES_W-1:0] sum_o
);

   logic [RES_W:0] raw_s;

   // Carry-inclusive add followed by one conditional subtract of the modulus
   always_comb begin
      raw_s = {1'b0, a_i} + {1'b0, b_i};
      if (raw_s >= MOD_WIDE) begin
         sum_o = residue_t'(raw_s - MOD_WIDE);
      end else begin
         sum_o = residue_t'(raw_s);
      end
   end

endmodule

// File: rtl/mod47_residue_accumulator.sv
// ----------------------------------------------------------------------------
// mod47_residue_accumulator
// Sums serial weighted chunk residues modulo 47 over one operand frame and
// presents the final residue under a valid/ready handshake.
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid_i  in   1      in_res_i / in_last_i valid
//   in_ready_o  out  1      beat taken when in_valid_i & in_ready_o
//   in_res_i    in   RES_W  weighted chunk residue
//   in_last_i   in   1      final beat of the operand frame
//   out_valid_o out  1      out_res_o / out_err_o valid
//   out_ready_i in   1      result taken when out_valid_o & out_ready_i
//   out_res_o   out  RES_W  operand residue mod MODULUS
//   out_err_o   out  1      frame error (over-length, plus range error)
// Optional feature macro: MOD47_ACC_RANGE_CHECK_EN
//   defined: in_res_i >= MODULUS is pre-reduced and flags a sticky frame error.
//   undefined: in_res_i must already be below MODULUS; no range logic.
// ----------------------------------------------------------------------------
module mod47_residue_accumulator
   import mod47_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [RES_W-1:0] in_res_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [RES_W-1:0] out_res_o,
   output logic             out_err_o
);

   state_t   state_q, state_d;
   residue_t acc_q, acc_d;
   count_t   cnt_q, cnt_d;
   residue_t out_res_q, out_res_d;
   logic     out_err_q, out_err_d;

   residue_t operand_s;
   residue_t sum_s;
   logic     accept_s;
   logic     handoff_s;
   logic     frame_err_s;

   assign in_ready_o  = (state_q == ACC);
   assign out_valid_o = (state_q == DONE);
   assign out_res_o   = out_res_q;
   assign out_err_o   = out_err_q;

   assign accept_s  = in_valid_i & (state_q == ACC);
   assign handoff_s = out_ready_i & (state_q == DONE);

`ifdef MOD47_ACC_RANGE_CHECK_EN
   logic     beat_err_s;
   logic     range_err_q, range_err_d;
   residue_t reduced_s;

   // Out-of-range values (47..63) fold back into range with one subtract
   mod47_add u_prereduce (
      .a_i   (in_res_i),
      .b_i   ({RES_W{1'b0}}),
      .sum_o (reduced_s)
   );

   assign beat_err_s  = (in_res_i >= residue_t'(MODULUS));
   assign operand_s   = reduced_s;
   assign frame_err_s = range_err_q | beat_err_s;

   // Sticky range error for the frame in progress; cleared on result handoff
   always_comb begin
      range_err_d = range_err_q;
      if (accept_s) begin
         range_err_d = range_err_q | beat_err_s;
      end else if (handoff_s) begin
         range_err_d = 1'b0;
      end else begin
         range_err_d = range_err_q;
      end
   end

   // Range error register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err_q <= 1'b0;
      end else begin
         range_err_q <= range_err_d;
      end
   end
`else
   assign operand_s   = in_res_i;
   assign frame_err_s = 1'b0;
`endif

   // Accumulate path: acc + incoming residue, mod 47
   mod47_add u_acc_add (
      .a_i   (acc_q),
      .b_i   (operand_s),
      .sum_o (sum_s)
   );

   // FSM next-state, accumulator, counter and result capture
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_res_d = out_res_q;
      out_err_d = out_err_q;
      case (state_q)
         ACC: begin
            if (accept_s) begin
               acc_d = sum_s;
               cnt_d = cnt_q + CNT_ONE;
               // Close on in_last or when the beat limit is reached;
               // hitting the limit without in_last is an over-length frame
               if (in_last_i || (cnt_q == CNT_LAST)) begin
                  state_d   = DONE;
                  out_res_d = sum_s;
                  out_err_d = ~in_last_i | frame_err_s;
               end else begin
                  state_d = ACC;
               end
            end else begin
               state_d = ACC;
            end
         end
         DONE: begin
            if (handoff_s) begin
               state_d   = ACC;
               acc_d     = {RES_W{1'b0}};
               cnt_d     = {CNT_W{1'b0}};
               out_err_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d   = ACC;
            acc_d     = {RES_W{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            out_err_d = 1'b0;
         end
      endcase
   end

   // State, accumulator, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= {RES_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         out_res_q <= {RES_W{1'b0}};
         out_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_res_q <= out_res_d;
         out_err_q <= out_err_d;
      end
   end

endmodule
